// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low hex segment table, blank pattern,
// capture FSM states and the decoder result type.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILTER,
    ST_HELD
  } cap_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } seg_dec_t;

  // Bit 0 = a ... bit 6 = g, low = lit.
  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/sseg_capture_if.sv
// Display-bus interface: scanned anode/segment lines in, reassembled frame out.
interface sseg_capture_if #(parameter int DIGITS = 4);
  logic [7:0]          an;
  logic [7:0]          sseg;
  logic [4*DIGITS-1:0] data;
  logic                data_valid;
  logic [DIGITS-1:0]   dp_bits;
  logic                seg_error;
  logic                an_error;

  modport master (output an, sseg, input data, data_valid, dp_bits, seg_error, an_error);
  modport slave  (input an, sseg, output data, data_valid, dp_bits, seg_error, an_error);
endinterface

// File: rtl/sseg_seg2hex.sv
// Combinational segment-pattern to {valid, nibble} decoder; blank and any
// pattern outside the hex table decode as invalid.
module sseg_seg2hex
  import sseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (hex2seg(4'(i)) == seg_i) begin
        dec_o.valid = 1'b1;
        dec_o.nib   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_capture.sv
// Receive-side decoder for a multiplexed seven-segment bus. Filters scan
// transitions, decodes stable digits and publishes a frame once all are seen.
// Define SSEG_CAPTURE_DP_EN to capture decimal points into dp_bits.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic           clk,
  input logic           clear_n,
  sseg_capture_if.slave bus
);

  localparam int               CW       = $clog2(STABLE_CYCLES + 1);
  localparam int               DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]    CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [7:0]       LOW_MASK = 8'((1 << DIGITS) - 1);
`ifdef SSEG_CAPTURE_DP_EN
  localparam logic [7:0]       DP_IGN   = 8'h00;
`else
  // dp forced inactive at the input so it neither restarts filtering nor lands in dp_bits
  localparam logic [7:0]       DP_IGN   = 8'h80;
`endif

  logic [7:0]               an_q, sseg_q, an_p_q, sseg_p_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  cap_state_e               state_q;
  logic [DIGITS-1:0]        seen_q, seen_d;
  logic [DIGITS-1:0][3:0]   nib_q, nib_d;
  logic [DIGITS-1:0]        dpr_q, dpr_d;
  logic [4*DIGITS-1:0]      data_q;
  logic [DIGITS-1:0]        dp_q;
  logic                     valid_q, seg_err_q, an_err_q;
  logic                     seg_err_d, an_err_d, done;
  logic                     changed, an_idle, an_ok, accept;
  logic [DW-1:0]            dig;
  seg_dec_t                 dec;

  sseg_seg2hex u_dec (.seg_i(sseg_q[6:0]), .dec_o(dec));

  assign changed = {an_q, sseg_q} != {an_p_q, sseg_p_q};
  assign an_idle = &an_q;
  assign an_ok   = (&(an_q | LOW_MASK)) && $onehot(~an_q & LOW_MASK);
  assign accept  = (state_q == ST_FILTER) && !an_idle && !changed && (cnt_q == CNT_LAST);
  assign cnt_d   = changed ? '0 : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1);

  always_comb begin
    dig = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an_q[i]) dig = DW'(i);
  end

  // Completion is resolved combinationally so data lands on the acceptance edge.
  always_comb begin
    seen_d    = seen_q;
    nib_d     = nib_q;
    dpr_d     = dpr_q;
    seg_err_d = 1'b0;
    an_err_d  = 1'b0;
    done      = 1'b0;
    if (accept) begin
      if (!an_ok) begin
        an_err_d = 1'b1;
        seen_d   = '0;
      end else if (!dec.valid) begin
        seg_err_d = 1'b1;
        seen_d    = '0;
      end else begin
        nib_d[dig]  = dec.nib;
        dpr_d[dig]  = ~sseg_q[7];
        seen_d[dig] = 1'b1;
        if (&seen_d) begin
          done   = 1'b1;
          seen_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      an_q      <= 8'hFF;
      sseg_q    <= 8'hFF;
      an_p_q    <= 8'hFF;
      sseg_p_q  <= 8'hFF;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      seen_q    <= '0;
      nib_q     <= '0;
      dpr_q     <= '0;
      data_q    <= '0;
      dp_q      <= '0;
      valid_q   <= 1'b0;
      seg_err_q <= 1'b0;
      an_err_q  <= 1'b0;
    end else begin
      an_q      <= bus.an;
      sseg_q    <= bus.sseg | DP_IGN;
      an_p_q    <= an_q;
      sseg_p_q  <= sseg_q;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      nib_q     <= nib_d;
      dpr_q     <= dpr_d;
      valid_q   <= done;
      seg_err_q <= seg_err_d;
      an_err_q  <= an_err_d;
      if (done) begin
        data_q <= nib_d;
        dp_q   <= dpr_d;
      end
      case (state_q)
        ST_IDLE:   if (!an_idle) state_q <= ST_FILTER;
        ST_FILTER: if (an_idle) state_q <= ST_IDLE;
                   else if (accept) state_q <= ST_HELD;
        ST_HELD:   if (changed) state_q <= an_idle ? ST_IDLE : ST_FILTER;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.dp_bits    = dp_q;
  assign bus.data_valid = valid_q;
  assign bus.seg_error  = seg_err_q;
  assign bus.an_error   = an_err_q;

endmodule
